adc_bcd_converter: RTL and testbench

ADC_BCD_CONVERTER -- requirements
Module: adc_bcd_converter

---
 rtl/adc_bcd_converter_if.sv | 36 +++
 rtl/adc_bcd_converter.sv | 148 ++++++++++++++
 tb/tb_adc_bcd_converter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_bcd_converter_if.sv
// Sample/result bundle between the SPI stage (master) and the BCD converter (slave).
interface adc_bcd_converter_if;
    logic [11:0] i_DATA;
    logic        DATA_VALID;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;
    logic        bcd_valid;
    logic        busy;
    logic        overrun;

    modport master (
        output i_DATA,
        output DATA_VALID,
        input  ones,
        input  tens,
        input  hundreds,
        input  thousands,
        input  bcd_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  i_DATA,
        input  DATA_VALID,
        output ones,
        output tens,
        output hundreds,
        output thousands,
        output bcd_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/adc_bcd_converter.sv
// 12-bit ADC sample to 4-digit BCD via sequential double dabble (13-clock latency).
// Define ADC_AVG4_EN to convert the truncated average of every four samples instead.
module adc_bcd_converter (
    input  logic                clk,
    input  logic                reset,
    adc_bcd_converter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        dv_prev;
    logic        trigger;
    logic        start;
    logic        drop;
    logic [11:0] start_value;
    logic        busy_int;

    logic [11:0] bin_shift;
    logic [15:0] bcd_scratch;
    logic [15:0] bcd_adjusted;
    logic [3:0]  iter_count;

    logic [3:0]  ones_q;
    logic [3:0]  tens_q;
    logic [3:0]  hundreds_q;
    logic [3:0]  thousands_q;
    logic        bcd_valid_q;
    logic        overrun_q;

    assign trigger  = bus.DATA_VALID & ~dv_prev;
    assign busy_int = (state != IDLE);

`ifdef ADC_AVG4_EN
    logic [13:0] acc;
    logic [1:0]  sample_count;
    logic [13:0] acc_sum;
    logic        fourth;

    // Samples 1-3 only accumulate, so they are accepted even mid-conversion.
    assign acc_sum     = acc + {2'b00, bus.i_DATA};
    assign fourth      = (sample_count == 2'd3);
    assign start       = trigger & fourth & ~busy_int;
    assign drop        = trigger & fourth & busy_int;
    assign start_value = acc_sum[13:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            sample_count <= '0;
        end else if (trigger && !fourth) begin
            acc          <= acc_sum;
            sample_count <= sample_count + 2'd1;
        end else if (start) begin
            acc          <= '0;
            sample_count <= '0;
        end
    end
`else
    assign start       = trigger & ~busy_int;
    assign drop        = trigger & busy_int;
    assign start_value = bus.i_DATA;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (iter_count == 4'd11) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adjusted = bcd_scratch;
        for (int i = 0; i < 4; i++) begin
            if (bcd_scratch[4*i +: 4] >= 4'd5) begin
                bcd_adjusted[4*i +: 4] = bcd_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dv_prev     <= 1'b0;
            bin_shift   <= '0;
            bcd_scratch <= '0;
            iter_count  <= '0;
            ones_q      <= '0;
            tens_q      <= '0;
            hundreds_q  <= '0;
            thousands_q <= '0;
            bcd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dv_prev     <= bus.DATA_VALID;
            bcd_valid_q <= 1'b0;
            overrun_q   <= drop;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_shift   <= start_value;
                        bcd_scratch <= '0;
                        iter_count  <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_scratch, bin_shift} <= {bcd_adjusted, bin_shift} << 1;
                    iter_count               <= iter_count + 4'd1;
                end
                DONE: begin
                    ones_q      <= bcd_scratch[3:0];
                    tens_q      <= bcd_scratch[7:4];
                    hundreds_q  <= bcd_scratch[11:8];
                    thousands_q <= bcd_scratch[15:12];
                    bcd_valid_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ones      = ones_q;
    assign bus.tens      = tens_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.thousands = thousands_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = busy_int;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_adc_bcd_converter.sv
// Directed bench for adc_bcd_converter: latency, digit values, hold, overrun and reset behaviour.
module tb_adc_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    int          testCount = 0;
    int          failCount = 0;
    int          validPulses = 0;
    int          overrunPulses = 0;
    logic [15:0] digitsOut;

    adc_bcd_converter_if bus ();

    adc_bcd_converter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign digitsOut = {bus.thousands, bus.hundreds, bus.tens, bus.ones};

    // Pulses last one full cycle, so one negedge sample counts each pulse once.
    always @(negedge clk) begin
        if (bus.bcd_valid) validPulses++;
        if (bus.overrun) overrunPulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] value);
        bus.i_DATA     = value;
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!bus.bcd_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic runConversion(input string tag, input logic [11:0] value, input logic [15:0] expected);
        int cycles;
        int validBase;
        validBase = validPulses;
        applyStimulus(value);
        bus.DATA_VALID = 1'b0;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        waitValid(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd13);
        checkOutput({tag, "_digits"}, 32'(digitsOut), 32'(expected));
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_clear"}, 32'(bus.bcd_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_pulses"}, 32'(validPulses - validBase), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int validBase;
        int overrunBase;

        reset          = 1'b0;
        bus.i_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_valid", 32'(bus.bcd_valid), 32'd0);
        checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
        checkOutput("reset_digits", 32'(digitsOut), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef ADC_AVG4_EN
        // Average of 100,200,300,401 is 1001>>2 = 250.
        validBase = validPulses;
        applyStimulus(12'd100);
        bus.DATA_VALID = 1'b0;
        checkOutput("avg_s1_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(12'd200);
        bus.DATA_VALID = 1'b0;
        checkOutput("avg_s2_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(12'd300);
        bus.DATA_VALID = 1'b0;
        checkOutput("avg_s3_busy", 32'(bus.busy), 32'd0);
        checkOutput("avg_early_valid", 32'(validPulses - validBase), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        runConversion("avg_s4", 12'd401, 16'h0250);
`else
        runConversion("zero", 12'd0, 16'h0000);
        runConversion("max", 12'd4095, 16'h4095);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold_digits", 32'(digitsOut), 32'h4095);

        // DATA_VALID held high must not retrigger.
        validBase   = validPulses;
        overrunBase = overrunPulses;
        applyStimulus(12'd1234);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("held_pulses", 32'(validPulses - validBase), 32'd1);
        checkOutput("held_overrun", 32'(overrunPulses - overrunBase), 32'd0);
        checkOutput("held_digits", 32'(digitsOut), 32'h1234);
        bus.DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Second edge lands at cycle 5 while the first conversion is running.
        validBase   = validPulses;
        overrunBase = overrunPulses;
        applyStimulus(12'h7D0);
        bus.DATA_VALID = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.i_DATA     = 12'd999;
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.DATA_VALID = 1'b0;
        checkOutput("ovr_pulse", 32'(bus.overrun), 32'd1);
        checkOutput("ovr_busy", 32'(bus.busy), 32'd1);
        waitValid(cycles);
        checkOutput("ovr_latency", 32'(cycles), 32'd8);
        checkOutput("ovr_digits", 32'(digitsOut), 32'h2000);
        @(posedge clk);
        #1;
        checkOutput("ovr_valid_count", 32'(validPulses - validBase), 32'd1);
        checkOutput("ovr_overrun_count", 32'(overrunPulses - overrunBase), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        runConversion("clean999", 12'd999, 16'h0999);

        // Reset in the middle of a conversion discards it.
        validBase = validPulses;
        applyStimulus(12'd3071);
        bus.DATA_VALID = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_digits", 32'(digitsOut), 32'd0);
        checkOutput("midrst_valid", 32'(bus.bcd_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("midrst_no_valid", 32'(validPulses - validBase), 32'd0);
        runConversion("after_rst42", 12'd42, 16'h0042);

        // DATA_VALID already high when reset releases counts as an edge.
        reset          = 1'b0;
        bus.i_DATA     = 12'd567;
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_release_busy", 32'(bus.busy), 32'd1);
        waitValid(cycles);
        checkOutput("rst_release_latency", 32'(cycles), 32'd13);
        checkOutput("rst_release_digits", 32'(digitsOut), 32'h0567);
        bus.DATA_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
